// File: rtl/spi_fsm_if.sv
// spi_fsm_if: handshake bundle between the SPI front end and the transaction
// sequencer.
//   cs, sclk_edge, rw_bit            : conditioned SPI inputs to the sequencer
//   addr_we, dm_we, sr_we, miso_buff : enables driven by the sequencer
// master drives the SPI inputs; slave is the sequencer side.
interface spi_fsm_if;
  logic cs;
  logic sclk_edge;
  logic rw_bit;
  logic addr_we;
  logic dm_we;
  logic sr_we;
  logic miso_buff;

  modport master (
    output cs, sclk_edge, rw_bit,
    input  addr_we, dm_we, sr_we, miso_buff
  );

  modport slave (
    input  cs, sclk_edge, rw_bit,
    output addr_we, dm_we, sr_we, miso_buff
  );
endinterface

// File: rtl/spi_fsm.sv
// spi_fsm: transaction sequencer for the SPI memory path. Frames each
// chip-select assertion as an address/command phase of WIDTH sclk edges
// followed by a data phase of WIDTH edges, and drives the address latch,
// data-memory write, shift-register load and MISO drive enables.
// Ports:
//   clk   : system clock
//   reset : asynchronous, active-high; forces IDLE
//   bus   : spi_fsm_if.slave (cs, sclk_edge, rw_bit in;
//           addr_we, dm_we, sr_we, miso_buff out)
//
// state      | meaning
// -----------+---------------------------------------------------
// IDLE       | waiting for cs low
// ADDR       | counting WIDTH address/command edges
// GOT        | address latched (addr_we); rw_bit decides direction
// READ_WAIT  | one cycle of data-memory read latency
// READ_LOAD  | parallel-load shift register (sr_we)
// READ_SHIFT | drive MISO (miso_buff) for WIDTH edges
// WR_DATA    | counting WIDTH write-data edges
// WR_COMMIT  | write data memory (dm_we)
// DONE       | transaction finished, waiting for cs high
module spi_fsm #(
  parameter int WIDTH = 8
) (
  input  logic      clk,
  input  logic      reset,
  spi_fsm_if.slave  bus
);

  localparam int            CW   = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [3:0] IDLE       = 4'd0;
  localparam logic [3:0] ADDR       = 4'd1;
  localparam logic [3:0] GOT        = 4'd2;
  localparam logic [3:0] READ_WAIT  = 4'd3;
  localparam logic [3:0] READ_LOAD  = 4'd4;
  localparam logic [3:0] READ_SHIFT = 4'd5;
  localparam logic [3:0] WR_DATA    = 4'd6;
  localparam logic [3:0] WR_COMMIT  = 4'd7;
  localparam logic [3:0] DONE       = 4'd8;

  logic [3:0]    state;
  logic [3:0]    state_next;
  logic [CW-1:0] cnt;
  logic          counting;
  logic          last_edge;

  assign counting  = (state == ADDR) || (state == WR_DATA) || (state == READ_SHIFT);
  assign last_edge = counting && bus.sclk_edge && (cnt == LAST);

  always_comb begin
    state_next = state;
    if (bus.cs) begin
      // abort outranks every other transition
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:       state_next = ADDR;
        ADDR:       if (last_edge) state_next = GOT;
        GOT:        state_next = bus.rw_bit ? READ_WAIT : WR_DATA;
        READ_WAIT:  state_next = READ_LOAD;
        READ_LOAD:  state_next = READ_SHIFT;
        READ_SHIFT: if (last_edge) state_next = DONE;
        WR_DATA:    if (last_edge) state_next = WR_COMMIT;
        WR_COMMIT:  state_next = DONE;
        DONE:       state_next = DONE;
        default:    state_next = IDLE;
      endcase
    end
  end

  // cnt clears on any state change, which covers entry into each counting
  // state and keeps it from ever reaching WIDTH on the terminal edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      if (state_next != state) begin
        cnt <= '0;
      end else if (counting && bus.sclk_edge) begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  // Moore decode: async reset of state clears these without a clock
  assign bus.addr_we   = (state == GOT);
  assign bus.dm_we     = (state == WR_COMMIT);
  assign bus.sr_we     = (state == READ_LOAD);
  assign bus.miso_buff = (state == READ_SHIFT);

endmodule
